// File: rtl/seq_bit_serializer_if.sv
// ---------------------------------------------------------------------------
// seq_bit_serializer_if
// Word-input handshake for the bit serializer.
//   in_data   : WIDTH-bit word to serialize        (master -> slave)
//   in_valid  : in_data is valid                   (master -> slave)
//   msb_first : bit order for this word, 1 = MSB   (master -> slave)
//   in_ready  : serializer accepts a word now      (slave  -> master)
// A word transfers on a rising clk edge where in_valid && in_ready.
// ---------------------------------------------------------------------------
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             msb_first;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        output msb_first,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  msb_first,
        output in_ready
    );
endinterface

// File: rtl/seq_bit_serializer.sv
// ---------------------------------------------------------------------------
// seq_bit_serializer
// Parallel-to-serial front end for the 1011 sequence detector. Words arrive
// over a valid/ready handshake and leave one bit per clock on out_bit, MSB or
// LSB first as latched at accept time. Consecutive words stream with no idle
// gap; out_bit is held at 0 whenever nothing is being shifted.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   bus        : seq_bit_serializer_if.slave (in_data, in_valid, msb_first,
//                in_ready)
//   out_bit    : serial data bit, 0 when out_valid = 0
//   out_valid  : out_bit carries a data bit this cycle
//   busy       : a word is shifting or waiting in the holding register
//   words_sent : number of completed words, 8-bit wrapping
//
// Build option
//   SER_SKID_EN : when defined, a one-word holding register lets a second
//                 word be accepted while the first is still shifting.
//                 in_ready then equals !hold_valid in every state.
// ---------------------------------------------------------------------------
module seq_bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    seq_bit_serializer_if.slave        bus,
    output logic                       out_bit,
    output logic                       out_valid,
    output logic                       busy,
    output logic [7:0]                 words_sent
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sh_reg, sh_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             ord_reg, ord_next;
    logic [7:0]       words_sent_reg, words_sent_next;

    logic [WIDTH-1:0] sh_left;
    logic [WIDTH-1:0] sh_right;
    logic             last_bit;
    logic             ready;
    logic             accept;
    logic             hold_occupied;

    // Word loaded into the shift register this edge (from input or buffer).
    logic             load_en;
    logic [WIDTH-1:0] load_data;
    logic             load_ord;

    // Zero-filled shifts toward the MSB (left) and LSB (right) output ends.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lo
                assign sh_left[gi] = 1'b0;
            end else begin : g_lo
                assign sh_left[gi] = sh_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_hi
                assign sh_right[gi] = 1'b0;
            end else begin : g_hi
                assign sh_right[gi] = sh_reg[gi+1];
            end
        end
    endgenerate

    assign last_bit = (state_reg == SHIFT) && (cnt_reg == LAST_CNT);

`ifdef SER_SKID_EN
    logic [WIDTH-1:0] hold_data_reg, hold_data_next;
    logic             hold_ord_reg, hold_ord_next;
    logic             hold_valid_reg, hold_valid_next;

    assign ready         = !hold_valid_reg;
    assign hold_occupied = hold_valid_reg;
`else
    // Without a buffer, a new word can only go straight into the shift
    // register, which is free in IDLE or on the edge ending the last bit.
    assign ready         = (state_reg == IDLE) || last_bit;
    assign hold_occupied = 1'b0;
`endif

    assign accept       = bus.in_valid && ready;
    assign bus.in_ready = ready;

    assign out_valid  = (state_reg == SHIFT);
    assign out_bit    = (state_reg == SHIFT) && (ord_reg ? sh_reg[WIDTH-1] : sh_reg[0]);
    assign busy       = (state_reg == SHIFT) || hold_occupied;
    assign words_sent = words_sent_reg;

    always_comb begin
        state_next      = state_reg;
        sh_next         = sh_reg;
        cnt_next        = cnt_reg;
        ord_next        = ord_reg;
        words_sent_next = words_sent_reg;
        load_en         = 1'b0;
        load_data       = bus.in_data;
        load_ord        = bus.msb_first;
`ifdef SER_SKID_EN
        hold_data_next  = hold_data_reg;
        hold_ord_next   = hold_ord_reg;
        hold_valid_next = hold_valid_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    load_en = 1'b1;
                end
            end
            SHIFT: begin
                sh_next  = ord_reg ? sh_left : sh_right;
                cnt_next = cnt_reg + 1'b1;
                if (last_bit) begin
                    words_sent_next = words_sent_reg + 8'd1;
`ifdef SER_SKID_EN
                    // Buffered word has priority; accept cannot coincide
                    // because in_ready is low while the buffer is full.
                    if (hold_valid_reg) begin
                        load_en         = 1'b1;
                        load_data       = hold_data_reg;
                        load_ord        = hold_ord_reg;
                        hold_valid_next = 1'b0;
                    end else if (accept) begin
                        load_en = 1'b1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
`else
                    if (accept) begin
                        load_en = 1'b1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
`endif
                end
`ifdef SER_SKID_EN
                else if (accept) begin
                    hold_data_next  = bus.in_data;
                    hold_ord_next   = bus.msb_first;
                    hold_valid_next = 1'b1;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load_en) begin
            sh_next    = load_data;
            ord_next   = load_ord;
            cnt_next   = '0;
            state_next = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            sh_reg         <= '0;
            cnt_reg        <= '0;
            ord_reg        <= 1'b0;
            words_sent_reg <= 8'd0;
        end else begin
            state_reg      <= state_next;
            sh_reg         <= sh_next;
            cnt_reg        <= cnt_next;
            ord_reg        <= ord_next;
            words_sent_reg <= words_sent_next;
        end
    end

`ifdef SER_SKID_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data_reg  <= '0;
            hold_ord_reg   <= 1'b0;
            hold_valid_reg <= 1'b0;
        end else begin
            hold_data_reg  <= hold_data_next;
            hold_ord_reg   <= hold_ord_next;
            hold_valid_reg <= hold_valid_next;
        end
    end
`endif

endmodule
